ifu_mem_resp: RTL

IFU_MEM_RESP -- requirements
Module: ifu_mem_resp

---
 rtl/ifu_mem_resp.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ifu_mem_resp.sv
// ifu_mem_resp -- single-outstanding instruction-fetch memory responder.
//
// Accepts one fetch address at a time, waits LATENCY cycles, then returns the
// 32-bit instruction word at that address, or an access fault.
//
// Optional feature macro: IFU_MEM_RESP_RAND_DELAY_EN
//   When defined, a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1) steps
//   every cycle. Its two LSBs, sampled at the request handshake, add 0..3
//   extra wait cycles. When undefined, latency is exactly LATENCY and no LFSR
//   exists.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous active-low reset
//   req_valid/ready  fetch request handshake (req_ready high only in IDLE)
//   req_addr         64-bit fetch pc
//   resp_valid/ready response handshake (resp_valid high only in RESP)
//   resp_inst        fetched instruction (32'h0 on fault)
//   resp_err         access fault: addr[1:0]!=0 or outside the memory window
//   vpmem_read_en    one-cycle doubleword read strobe (vpmem_read port)
//   vpmem_read_addr  doubleword-aligned read address
//   vpmem_read_data  64-bit read data, returned combinationally
//   dbg_state        current FSM state (0=IDLE, 1=WAIT, 2=RESP)
//
// Handshake rule: a transfer happens on a rising edge where valid && ready.
// Once valid is raised it holds, with stable payload, until that edge.

module ifu_mem_resp #(
  parameter int unsigned LATENCY  = 2,
  parameter logic [63:0] MEM_BASE = 64'h8000_0000,
  parameter logic [63:0] MEM_SIZE = 64'h0800_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_inst,
  output logic        resp_err,
  output logic        vpmem_read_en,
  output logic [63:0] vpmem_read_addr,
  input  logic [63:0] vpmem_read_data,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [4:0]  LAT       = 5'(LATENCY);
  // One bit wider than the address so the window end cannot wrap.
  localparam logic [64:0] MEM_LIMIT = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d;
  logic [31:0] inst_q, inst_d;
  logic        err_q, err_d;

  logic [4:0]  extra_cyc;
  logic [4:0]  total_wait;
  logic [63:0] fetch_addr;
  logic        fetch_err;
  logic        enter_resp;

`ifdef IFU_MEM_RESP_RAND_DELAY_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Right-shifting form of x^16+x^14+x^13+x^11+1 (taps 0,2,3,5).
  always_comb begin
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= 16'hACE1;
    else      lfsr_q <= lfsr_d;
  end

  assign extra_cyc = {3'b000, lfsr_q[1:0]};
`else
  assign extra_cyc = 5'd0;
`endif

  assign total_wait = LAT + extra_cyc;

  // With zero wait the read happens on the handshake edge itself, before
  // the address has been latched, so take it straight from the request.
  assign fetch_addr = (state_q == S_IDLE) ? req_addr : addr_q;
  assign fetch_err  = (fetch_addr[1:0] != 2'b00) ||
                      (fetch_addr < MEM_BASE) ||
                      ({1'b0, fetch_addr} >= MEM_LIMIT);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    inst_d     = inst_q;
    err_d      = err_q;
    enter_resp = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          if (total_wait == 5'd0) begin
            state_d    = S_RESP;
            cnt_d      = 5'd0;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = total_wait;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 5'd1;
        // Counter reading 1 is the last wait cycle; <= guards a stray 0.
        if (cnt_q <= 5'd1) begin
          state_d    = S_RESP;
          cnt_d      = 5'd0;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 5'd0;
      end
    endcase

    // Response payload is captured once on entry and then held, so it stays
    // stable for as long as the consumer stalls.
    if (enter_resp) begin
      err_d = fetch_err;
      if (fetch_err)          inst_d = 32'h0;
      else if (fetch_addr[2]) inst_d = vpmem_read_data[63:32];
      else                    inst_d = vpmem_read_data[31:0];
    end
  end

  // Faulting accesses never touch memory.
  assign vpmem_read_en   = enter_resp && !fetch_err;
  assign vpmem_read_addr = {fetch_addr[63:3], 3'b000};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      addr_q  <= 64'h0;
      inst_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_inst  = inst_q;
  assign resp_err   = err_q;
  assign dbg_state  = state_q;

endmodule
